// File: rtl/dual_rail_pkg.sv
// Shared types and rail-encoding helpers for the dual-rail handshake counter.
package dual_rail_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACKH = 2'd2,
    RTZ  = 2'd3
  } state_e;

  typedef struct packed {
    logic t;
    logic f;
  } rail_t;

  function automatic rail_t encode(input logic b);
    rail_t r;
    r.t = b;
    r.f = ~b;
    return r;
  endfunction

  function automatic rail_t spacer();
    rail_t r;
    r.t = 1'b0;
    r.f = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/dual_rail_encoder.sv
// Combinational WIDTH-bit dual-rail encoder; vld=0 yields the all-zero spacer.
module dual_rail_encoder
  import dual_rail_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] val,
  input  logic             vld,
  output logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] f
);

  rail_t r;

  always_comb begin
    t = '0;
    f = '0;
    r = spacer();
    for (int i = 0; i < WIDTH; i++) begin
      r    = vld ? encode(val[i]) : spacer();
      t[i] = r.t;
      f[i] = r.f;
    end
  end

endmodule

// File: rtl/dual_rail_hs_counter.sv
// Four-phase req/ack counter presenting each new count (plus carry/limit) as a
// return-to-zero dual-rail token; sticky err flags handshake violations.
module dual_rail_hs_counter
  import dual_rail_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int RESET_VALUE = 0,
  parameter bit SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             up,
  input  logic             clr,
  output logic             ack,
  output logic [WIDTH-1:0] cnt_t,
  output logic [WIDTH-1:0] cnt_f,
  output logic             cy_t,
  output logic             cy_f,
  output logic             err
);

  localparam logic [WIDTH-1:0] RST_CNT  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_e           state;
  logic [WIDTH-1:0] cnt;
  logic             cy;
  logic             tok_vld;

  logic [WIDTH-1:0] nxt_cnt;
  logic             nxt_cy;
  logic             load;
  logic             drop;
  logic             enc_vld;
  logic [WIDTH-1:0] enc_cnt;
  logic             enc_cy;
  logic [WIDTH-1:0] enc_cnt_t;
  logic [WIDTH-1:0] enc_cnt_f;
  logic             enc_cy_t;
  logic             enc_cy_f;

  always_comb begin
    nxt_cnt = cnt;
    nxt_cy  = 1'b0;
    if (clr) begin
      nxt_cnt = RST_CNT;
      nxt_cy  = 1'b0;
    end else if (up) begin
      nxt_cy  = (cnt == ALL_ONES);
      nxt_cnt = (nxt_cy && SATURATE) ? cnt : cnt + ONE;
    end else begin
      nxt_cy  = (cnt == '0);
      nxt_cnt = (nxt_cy && SATURATE) ? cnt : cnt - ONE;
    end
  end

  // Rails are re-registered from the encoder every cycle, so the token is
  // selected here: fresh value on load, held value while valid, else spacer.
  always_comb begin
    load    = (state == IDLE) && req;
    drop    = (state == ACKH) && !req;
    enc_vld = load || (tok_vld && !drop);
    enc_cnt = load ? nxt_cnt : cnt;
    enc_cy  = load ? nxt_cy : cy;
  end

  dual_rail_encoder #(.WIDTH(WIDTH)) u_cnt_enc (
    .val (enc_cnt),
    .vld (enc_vld),
    .t   (enc_cnt_t),
    .f   (enc_cnt_f)
  );

  dual_rail_encoder #(.WIDTH(1)) u_cy_enc (
    .val (enc_cy),
    .vld (enc_vld),
    .t   (enc_cy_t),
    .f   (enc_cy_f)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ack     <= 1'b0;
      err     <= 1'b0;
      cnt     <= RST_CNT;
      cy      <= 1'b0;
      tok_vld <= 1'b0;
      cnt_t   <= '0;
      cnt_f   <= '0;
      cy_t    <= 1'b0;
      cy_f    <= 1'b0;
    end else begin
      tok_vld <= enc_vld;
      cnt_t   <= enc_cnt_t;
      cnt_f   <= enc_cnt_f;
      cy_t    <= enc_cy_t;
      cy_f    <= enc_cy_f;
      if (load) begin
        cnt <= nxt_cnt;
        cy  <= nxt_cy;
      end
      case (state)
        IDLE: begin
          if (req) state <= DATA;
        end
        DATA: begin
          ack   <= 1'b1;
          state <= ACKH;
          if (!req) err <= 1'b1;
        end
        ACKH: begin
          if (!req) state <= RTZ;
        end
        RTZ: begin
          ack   <= 1'b0;
          state <= IDLE;
          if (req) err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_rail_hs_counter.sv
// Scoreboard bench: two counter configurations driven by one handshake stream,
// checked against an arithmetic model of the counting rules.
module tb_dual_rail_hs_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic up  = 1'b1;
  logic clr = 1'b0;

  logic       ack_a, cy_t_a, cy_f_a, err_a;
  logic [1:0] cnt_t_a, cnt_f_a;
  logic       ack_b, cy_t_b, cy_f_b, err_b;
  logic [3:0] cnt_t_b, cnt_f_b;

  always #5 clk = ~clk;

  dual_rail_hs_counter #(.WIDTH(2), .RESET_VALUE(0), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .req(req), .up(up), .clr(clr),
    .ack(ack_a), .cnt_t(cnt_t_a), .cnt_f(cnt_f_a),
    .cy_t(cy_t_a), .cy_f(cy_f_a), .err(err_a)
  );

  dual_rail_hs_counter #(.WIDTH(4), .RESET_VALUE(14), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .up(up), .clr(clr),
    .ack(ack_b), .cnt_t(cnt_t_b), .cnt_f(cnt_f_b),
    .cy_t(cy_t_b), .cy_f(cy_f_b), .err(err_b)
  );

  typedef struct {
    int cnt;
    bit cy;
  } tok_t;

  tok_t qa[$];
  tok_t qb[$];
  int   ma, mb;
  int   vectors = 0;
  int   miscompares = 0;
  bit   exp_err = 1'b0;

  function automatic tok_t model(input int w, input bit sat, input int rv,
                                 input int cur, input bit u, input bit c);
    tok_t r;
    int   top;
    top = (1 << w) - 1;
    if (c) begin
      r.cnt = rv;
      r.cy  = 1'b0;
    end else if (u) begin
      r.cy  = (cur == top);
      r.cnt = r.cy ? (sat ? top : 0) : cur + 1;
    end else begin
      r.cy  = (cur == 0);
      r.cnt = r.cy ? (sat ? 0 : top) : cur - 1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_tok(input string name, input tok_t e, input int w,
                         input int t, input int f, input bit yt, input bit yf);
    int mask;
    mask = (1 << w) - 1;
    chk({name, "_cnt_t"}, t, e.cnt);
    chk({name, "_cnt_f"}, f, (~e.cnt) & mask);
    chk({name, "_cy"}, {yt, yf}, e.cy ? 2 : 1);
  endtask

  // Monitor: pops the scoreboard whenever ack rises, and checks spacer when it falls.
  logic       pa_ack, pb_ack;
  logic [1:0] pa_t, pa_f;
  logic [3:0] pb_t, pb_f;
  logic       pa_yt, pa_yf, pb_yt, pb_yf;
  tok_t       e;

  initial begin
    pa_ack = 0; pb_ack = 0; pa_t = 0; pa_f = 0; pb_t = 0; pb_f = 0;
    pa_yt = 0; pa_yf = 0; pb_yt = 0; pb_yf = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (ack_a && !pa_ack) begin
          if (qa.size() == 0) begin
            chk("a_unexpected_token", 1, 0);
          end else begin
            e = qa.pop_front();
            chk_tok("a_tok", e, 2, int'(cnt_t_a), int'(cnt_f_a), cy_t_a, cy_f_a);
            chk_tok("a_tok_early", e, 2, int'(pa_t), int'(pa_f), pa_yt, pa_yf);
          end
        end
        if (!ack_a && pa_ack) begin
          chk("a_rtz_now", int'({cnt_t_a, cnt_f_a, cy_t_a, cy_f_a}), 0);
          chk("a_rtz_early", int'({pa_t, pa_f, pa_yt, pa_yf}), 0);
        end
        if (ack_b && !pb_ack) begin
          if (qb.size() == 0) begin
            chk("b_unexpected_token", 1, 0);
          end else begin
            e = qb.pop_front();
            chk_tok("b_tok", e, 4, int'(cnt_t_b), int'(cnt_f_b), cy_t_b, cy_f_b);
            chk_tok("b_tok_early", e, 4, int'(pb_t), int'(pb_f), pb_yt, pb_yf);
          end
        end
        if (!ack_b && pb_ack) begin
          chk("b_rtz_now", int'({cnt_t_b, cnt_f_b, cy_t_b, cy_f_b}), 0);
          chk("b_rtz_early", int'({pb_t, pb_f, pb_yt, pb_yf}), 0);
        end
      end
      pa_ack = ack_a; pa_t = cnt_t_a; pa_f = cnt_f_a; pa_yt = cy_t_a; pa_yf = cy_f_a;
      pb_ack = ack_b; pb_t = cnt_t_b; pb_f = cnt_f_b; pb_yt = cy_t_b; pb_yf = cy_f_b;
    end
  end

  task automatic push(input bit u, input bit c);
    tok_t ta, tb;
    ta = model(2, 1'b0, 0, ma, u, c);
    tb = model(4, 1'b1, 14, mb, u, c);
    ma = ta.cnt;
    mb = tb.cnt;
    qa.push_back(ta);
    qb.push_back(tb);
  endtask

  task automatic wait_ack(input bit lvl, input string name);
    int n;
    n = 0;
    while (ack_a !== lvl && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ack_a !== lvl) chk({name, "_timeout"}, int'(ack_a), int'(lvl));
  endtask

  task automatic hs(input bit u, input bit c, input int hold);
    @(negedge clk);
    req = 1'b1; up = u; clr = c;
    push(u, c);
    wait_ack(1'b1, "ack_rise");
    repeat (hold) @(negedge clk);
    req = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 1'b0; up = 1'b1; clr = 1'b0;
    ma = 0; mb = 14; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a_outs", int'({ack_a, cnt_t_a, cnt_f_a, cy_t_a, cy_f_a, err_a}), 0);
    chk("rst_b_outs", int'({ack_b, cnt_t_b, cnt_f_b, cy_t_b, cy_f_b, err_b}), 0);
    rst = 1'b0;
  endtask

  initial begin
    ma = 0; mb = 14;
    do_reset();

    // Up-count wrap / saturation from reset.
    for (int i = 0; i < 5; i++) hs(1'b1, 1'b0, 0);
    chk("err_a_clean", int'(err_a), 0);

    // Down-count underflow.
    do_reset();
    hs(1'b0, 1'b0, 0);
    hs(1'b0, 1'b0, 1);

    // Clear mid-sequence, then resume counting.
    do_reset();
    hs(1'b1, 1'b0, 0);
    hs(1'b1, 1'b0, 0);
    hs(1'b1, 1'b1, 0);
    hs(1'b1, 1'b0, 2);

    // Reset while holding ack high.
    hs(1'b1, 1'b0, 0);
    @(negedge clk);
    req = 1'b1; up = 1'b1; clr = 1'b0;
    push(1'b1, 1'b0);
    wait_ack(1'b1, "ackh_rise");
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    ma = 0; mb = 14;
    @(negedge clk);
    chk("mid_rst_a", int'({ack_a, cnt_t_a, cnt_f_a, cy_t_a, cy_f_a, err_a}), 0);
    chk("mid_rst_b", int'({ack_b, cnt_t_b, cnt_f_b, cy_t_b, cy_f_b, err_b}), 0);
    rst = 1'b0;
    hs(1'b1, 1'b0, 0);

    // Protocol violations: req drops in DATA, then req pulses during RTZ.
    @(negedge clk);
    req = 1'b1; up = 1'b1; clr = 1'b0;
    push(1'b1, 1'b0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("err_a_data_drop", int'(err_a), 1);
    chk("err_b_data_drop", int'(err_b), 1);
    wait_ack(1'b1, "viol_ack");
    @(negedge clk);
    chk("viol_rtz_a", int'({ack_a, cnt_t_a, cnt_f_a}), 16);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("viol_ack_low", int'(ack_a), 0);
    repeat (2) @(negedge clk);
    chk("no_extra_tok_a", int'({cnt_t_a, cnt_f_a, cy_t_a, cy_f_a}), 0);
    chk("no_extra_tok_b", int'({cnt_t_b, cnt_f_b, cy_t_b, cy_f_b}), 0);
    chk("err_a_sticky", int'(err_a), 1);
    chk("err_b_sticky", int'(err_b), 1);
    hs(1'b1, 1'b0, 0);
    chk("err_a_still", int'(err_a), 1);
    do_reset();

    // Random handshakes.
    for (int i = 0; i < 60; i++) begin
      hs(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk("err_a_random", int'(err_a), int'(exp_err));
    chk("err_b_random", int'(err_b), int'(exp_err));

    repeat (4) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
